t08_i2c_touch_target: RTL and testbench

Synthesizable I2C target (responder) that emulates the touchscreen controller on the team 08 touch bus, the far end of the `t08_top` I2C host port. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, accepts a register pointer and returns touch-point registers with auto-increment. It raises an active-low interrupt on each new touch. It is used both in module benches against `t08_top` and as an FPGA stand-in for the real panel.

---
 rtl/t08_touch_pkg.sv | 33 +++
 rtl/t08_i2c_edge_detect.sv | 92 +++++++++
 rtl/t08_i2c_touch_target.sv | 177 +++++++++++++++++
 tb/tb_t08_i2c_touch_target.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_touch_pkg.sv
// Shared types and constants for the team 08 touch-panel I2C target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t08_touch_pkg;

   // Default 7-bit bus address of the touch controller
   localparam logic [6:0] T08_TOUCH_ADDR_DEFAULT = 7'h38;

   // Readable touch-point registers; every other address reads as zero
   localparam logic [7:0] REG_TD_STATUS = 8'h02;
   localparam logic [7:0] REG_P1_XH     = 8'h03;
   localparam logic [7:0] REG_P1_XL     = 8'h04;
   localparam logic [7:0] REG_P1_YH     = 8'h05;
   localparam logic [7:0] REG_P1_YL     = 8'h06;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_TX,
      ST_TX_ACKCHK,
      ST_WAIT_STOP
   } t08_i2c_tgt_state_t;

   // 2-of-3 vote used by the optional line glitch filter
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/t08_i2c_edge_detect.sv
// Conditions async SCL/SDA and emits one-cycle scl_rise/scl_fall/start/stop pulses.
// Latency: bus edge to pulse 3 clk, or 5 clk with T08_TOUCH_TARGET_GLITCH_FILTER_EN.
// Backpressure: none; pulses are fire-and-forget, o_sda is aligned with the pulses.
module t08_i2c_edge_detect
   import t08_touch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop,
   output logic o_sda
);
   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       w_scl;
   logic       w_sda;
   logic       r_scl_q;
   logic       r_sda_q;
   logic       r_scl_rise;
   logic       r_scl_fall;
   logic       r_start;
   logic       r_stop;

   // Two-flop synchronizers; reset to the idle-bus level so no edge appears out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda};
      end
   end

`ifdef T08_TOUCH_TARGET_GLITCH_FILTER_EN
   logic [1:0] r_scl_hist;
   logic [1:0] r_sda_hist;
   logic       r_scl_filt;
   logic       r_sda_filt;

   // Majority of three consecutive samples: single-cycle pulses never win the vote
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_hist <= 2'b11;
         r_sda_hist <= 2'b11;
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
      end else begin
         r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
         r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
         r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
      end
   end

   assign w_scl = r_scl_filt;
   assign w_sda = r_sda_filt;
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif

   // Edge and bus-condition pulses; START/STOP need SCL high both before and after the SDA edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_q    <= 1'b1;
         r_sda_q    <= 1'b1;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
      end else begin
         r_scl_q    <= w_scl;
         r_sda_q    <= w_sda;
         r_scl_rise <= ~r_scl_q & w_scl;
         r_scl_fall <= r_scl_q & ~w_scl;
         r_start    <= r_scl_q & w_scl & r_sda_q & ~w_sda;
         r_stop     <= r_scl_q & w_scl & ~r_sda_q & w_sda;
      end
   end

   assign o_scl_rise = r_scl_rise;
   assign o_scl_fall = r_scl_fall;
   assign o_start    = r_start;
   assign o_stop     = r_stop;
   assign o_sda      = r_sda_q;

endmodule

// File: rtl/t08_i2c_touch_target.sv
// I2C target emulating the team 08 touch controller: address match, pointer write, auto-increment reads, touch IRQ.
// Latency: bus edge seen after 3 clk (5 with T08_TOUCH_TARGET_GLITCH_FILTER_EN); SDA moves the cycle after a detected SCL fall.
// Backpressure: none toward the host beyond ACK/NACK; touch_valid is always accepted.
module t08_i2c_touch_target
   import t08_touch_pkg::*;
#(
   parameter logic [6:0] ADDR  = T08_TOUCH_ADDR_DEFAULT,
   parameter int         NREGS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_out,
   output logic        sda_oeb,
   input  logic        touch_valid,
   input  logic [11:0] touch_x,
   input  logic [11:0] touch_y,
   output logic        touch_int_n,
   output logic        busy
);
   localparam int PW = $clog2(NREGS);

   t08_i2c_tgt_state_t r_state;
   t08_i2c_tgt_state_t w_state_nxt;
   logic               w_scl_rise;
   logic               w_scl_fall;
   logic               w_start;
   logic               w_stop;
   logic               w_sda;
   logic [2:0]         r_bit_cnt;
   logic               r_byte_done;
   logic [7:0]         r_shift;
   logic               r_host_ack;
   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      r_tx_addr;
   logic               r_touched;
   logic [11:0]        r_x;
   logic [11:0]        r_y;
   logic               r_int_n;
   logic               r_sda_oeb;
   logic [7:0]         w_rd_dat;
   logic               w_addr_match;
   logic               w_rx_state;
   logic               w_load_tx;
   logic               w_int_clr;

   t08_i2c_edge_detect u_edge (
      .clk        (clk),
      .rst        (rst),
      .i_scl      (scl_in),
      .i_sda      (sda_in),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop),
      .o_sda      (w_sda)
   );

   assign w_addr_match = (r_shift[7:1] == ADDR);
   assign w_rx_state   = (r_state == ST_ADDR) || (r_state == ST_PTR) || (r_state == ST_WDATA);
   assign w_load_tx    = (w_state_nxt == ST_TX) && (r_state != ST_TX);
   assign w_int_clr    = (r_state == ST_TX) && (w_state_nxt == ST_TX_ACKCHK) &&
                         (8'(r_tx_addr) == REG_P1_YL);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state: START/STOP override everything, otherwise byte boundaries advance on SCL fall
   always_comb begin
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = ST_ADDR;
      end else if (w_stop) begin
         w_state_nxt = ST_IDLE;
      end else if (w_scl_fall) begin
         case (r_state)
            ST_ADDR:      if (r_byte_done) w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK:  w_state_nxt = r_shift[0] ? ST_TX : ST_PTR;
            ST_PTR:       if (r_byte_done) w_state_nxt = ST_PTR_ACK;
            ST_WDATA:     if (r_byte_done) w_state_nxt = ST_PTR_ACK;
            ST_PTR_ACK:   w_state_nxt = ST_WDATA;
            ST_TX:        if (r_byte_done) w_state_nxt = ST_TX_ACKCHK;
            ST_TX_ACKCHK: w_state_nxt = r_host_ack ? ST_TX : ST_WAIT_STOP;
            default:      w_state_nxt = r_state;
         endcase
      end
   end

   // Read mux for the byte about to be loaded into the shifter
   always_comb begin
      w_rd_dat = 8'h00;
      case (8'(r_ptr))
         REG_TD_STATUS: w_rd_dat = {7'b0, r_touched};
         REG_P1_XH:     w_rd_dat = {2'b00, 2'b00, r_x[11:8]};
         REG_P1_XL:     w_rd_dat = r_x[7:0];
         REG_P1_YH:     w_rd_dat = {4'h0, r_y[11:8]};
         REG_P1_YL:     w_rd_dat = r_y[7:0];
         default:       w_rd_dat = 8'h00;
      endcase
   end

   // Bit counter, shifter, pointer, host-ACK capture and SDA drive, all stepped by bus events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_byte_done <= 1'b0;
         r_shift     <= '0;
         r_host_ack  <= 1'b0;
         r_ptr       <= '0;
         r_tx_addr   <= '0;
         r_sda_oeb   <= 1'b1;
      end else begin
         if (w_start || (w_state_nxt != r_state)) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
         end else if (w_scl_rise && (w_rx_state || r_state == ST_TX)) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
         end

         if (w_load_tx)
            r_shift <= w_rd_dat;
         else if (r_state == ST_TX && w_scl_fall && !r_byte_done)
            r_shift <= {r_shift[6:0], 1'b0};
         else if (w_rx_state && w_scl_rise)
            r_shift <= {r_shift[6:0], w_sda};

         if (r_state == ST_PTR && w_state_nxt == ST_PTR_ACK)
            r_ptr <= r_shift[PW-1:0];
         else if (w_load_tx) begin
            r_ptr     <= r_ptr + PW'(1);
            r_tx_addr <= r_ptr;
         end

         if (r_state == ST_TX_ACKCHK && w_scl_rise)
            r_host_ack <= ~w_sda;

         // SDA only moves after a detected SCL fall; bus conditions always release it
         if (w_start || w_stop)
            r_sda_oeb <= 1'b1;
         else if (w_scl_fall) begin
            case (w_state_nxt)
               ST_ADDR_ACK, ST_PTR_ACK: r_sda_oeb <= 1'b0;
               ST_TX:                   r_sda_oeb <= w_load_tx ? w_rd_dat[7] : r_shift[6];
               default:                 r_sda_oeb <= 1'b1;
            endcase
         end
      end
   end

   // Touch capture and interrupt; a new touch beats the read-out clear in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_touched <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_int_n   <= 1'b1;
      end else if (touch_valid) begin
         r_touched <= 1'b1;
         r_x       <= touch_x;
         r_y       <= touch_y;
         r_int_n   <= 1'b0;
      end else if (w_int_clr) begin
         r_int_n   <= 1'b1;
      end
   end

   assign sda_out     = 1'b0;
   assign sda_oeb     = r_sda_oeb;
   assign touch_int_n = r_int_n;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_t08_i2c_touch_target.sv
// Bench for the touch-panel I2C target: bit-banged open-drain host, expected read bytes queued before each read.
// Latency: n/a.
// Backpressure: n/a.
module tb_t08_i2c_touch_target;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl_h;
   logic        sda_h;
   logic        sda_bus;
   logic        sda_out;
   logic        sda_oeb;
   logic        touch_valid;
   logic [11:0] touch_x;
   logic [11:0] touch_y;
   logic        touch_int_n;
   logic        busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and target
   assign sda_bus = sda_h & (sda_oeb | sda_out);

   t08_i2c_touch_target dut (
      .clk         (clk),
      .rst         (rst),
      .scl_in      (scl_h),
      .sda_in      (sda_bus),
      .sda_out     (sda_out),
      .sda_oeb     (sda_oeb),
      .touch_valid (touch_valid),
      .touch_x     (touch_x),
      .touch_y     (touch_y),
      .touch_int_n (touch_int_n),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_h = 1'b1; tick(H);
      scl_h = 1'b1; tick(H);
      sda_h = 1'b0; tick(H);
      scl_h = 1'b0; tick(2);
   endtask

   task automatic i2c_stop();
      sda_h = 1'b0; tick(H);
      scl_h = 1'b1; tick(H);
      sda_h = 1'b1; tick(H);
   endtask

   task automatic send_bit(input logic b);
      sda_h = b;    tick(H);
      scl_h = 1'b1; tick(H);
      scl_h = 1'b0; tick(2);
   endtask

   task automatic recv_bit(output logic b);
      sda_h = 1'b1; tick(H);
      scl_h = 1'b1; tick(H / 2);
      b = sda_bus;  tick(H / 2);
      scl_h = 1'b0; tick(2);
   endtask

   // Sends a byte and compares the target's ACK (1 = acknowledged)
   task automatic write_byte(input logic [7:0] d, input string tag, input logic exp_ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      check(tag, {31'b0, ~b}, {31'b0, exp_ack});
   endtask

   // Reads a byte, answers ACK/NACK, and checks it against the head of the expectation queue
   task automatic read_byte(input logic host_ack, input string tag);
      logic [7:0] d;
      logic [7:0] e;
      logic       b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(~host_ack);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 8'hxx;
      check(tag, {24'b0, d}, {24'b0, e});
   endtask

   task automatic read_bytes(input int n, input string tag);
      for (int i = 0; i < n; i++) read_byte(i != n - 1, tag);
   endtask

   task automatic pulse_touch(input logic [11:0] x, input logic [11:0] y);
      touch_valid = 1'b1; touch_x = x; touch_y = y;
      tick(1);
      touch_valid = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen_low;
      logic seen_busy;
      logic exp_glitch;

      rst = 1'b1; scl_h = 1'b1; sda_h = 1'b1;
      touch_valid = 1'b0; touch_x = '0; touch_y = '0;
      tick(4);
      check("rst_sda_oeb", {31'b0, sda_oeb}, 32'd1);
      check("rst_int_n",   {31'b0, touch_int_n}, 32'd1);
      check("rst_busy",    {31'b0, busy}, 32'd0);
      rst = 1'b0;

      // 1: idle bus never sees an ACK
      seen_low = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (!sda_oeb) seen_low = 1'b1;
      end
      check("idle_no_ack", {31'b0, seen_low}, 32'd0);

      // 2: touch, pointer 0x02, repeated START, five-byte read
      pulse_touch(12'h1A5, 12'h2C3);
      check("touch_int_low", {31'b0, touch_int_n}, 32'd0);
      i2c_start();
      check("busy_after_start", {31'b0, busy}, 32'd1);
      write_byte(8'h70, "t2_addr_w", 1'b1);
      write_byte(8'h02, "t2_ptr", 1'b1);
      i2c_start();
      write_byte(8'h71, "t2_addr_r", 1'b1);
      exp_q.push_back(8'h01); exp_q.push_back(8'h01);
      exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
      for (int i = 0; i < 4; i++) read_byte(1'b1, "t2_data");
      check("int_low_before_yl", {31'b0, touch_int_n}, 32'd0);
      exp_q.push_back(8'hC3);
      read_byte(1'b0, "t2_data_yl");
      check("int_high_after_yl", {31'b0, touch_int_n}, 32'd1);
      i2c_stop();
      check("busy_after_stop", {31'b0, busy}, 32'd0);

      // 3: wrong address is NACKed and leaves the pointer alone
      i2c_start();
      write_byte(8'h70, "t3_addr_w", 1'b1);
      write_byte(8'h04, "t3_ptr", 1'b1);
      i2c_stop();
      i2c_start();
      write_byte(8'h72, "t3_addr_39", 1'b0);
      write_byte(8'h0F, "t3_ptr_ignored", 1'b0);
      i2c_stop();
      i2c_start();
      write_byte(8'h71, "t3_addr_r", 1'b1);
      exp_q.push_back(8'hA5);
      read_bytes(1, "t3_data");
      i2c_stop();

      // 4: pointer wraps from 0x0F
      i2c_start();
      write_byte(8'h70, "t4_addr_w", 1'b1);
      write_byte(8'h0F, "t4_ptr", 1'b1);
      i2c_start();
      write_byte(8'h71, "t4_addr_r", 1'b1);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      read_bytes(3, "t4_wrap_data");
      i2c_stop();
      i2c_start();
      write_byte(8'h71, "t4_addr_r2", 1'b1);
      exp_q.push_back(8'h01);
      read_bytes(1, "t4_after_wrap");
      i2c_stop();

      // 5: STOP in the middle of the address byte
      i2c_start();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      i2c_stop();
      check("t5_busy", {31'b0, busy}, 32'd0);
      check("t5_sda_oeb", {31'b0, sda_oeb}, 32'd1);
      i2c_start();
      write_byte(8'h70, "t5_addr_w", 1'b1);
      write_byte(8'h03, "t5_ptr", 1'b1);
      i2c_start();
      write_byte(8'h71, "t5_addr_r", 1'b1);
      exp_q.push_back(8'h01); exp_q.push_back(8'hA5);
      read_bytes(2, "t5_data");
      i2c_stop();

      // New touch reloads the registers and re-arms the interrupt
      pulse_touch(12'hFFF, 12'h123);
      check("t7_int_low", {31'b0, touch_int_n}, 32'd0);
      i2c_start();
      write_byte(8'h70, "t7_addr_w", 1'b1);
      write_byte(8'h03, "t7_ptr", 1'b1);
      i2c_start();
      write_byte(8'h71, "t7_addr_r", 1'b1);
      exp_q.push_back(8'h0F); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h01); exp_q.push_back(8'h23);
      read_bytes(4, "t7_data");
      check("t7_int_high", {31'b0, touch_int_n}, 32'd1);
      i2c_stop();

      // 6: one-clock SDA glitch while SCL is high
      tick(20);
      seen_busy = 1'b0;
      sda_h = 1'b0; tick(1);
      sda_h = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (busy) seen_busy = 1'b1;
      end
`ifdef T08_TOUCH_TARGET_GLITCH_FILTER_EN
      exp_glitch = 1'b0;
`else
      exp_glitch = 1'b1;
`endif
      check("t6_glitch_start", {31'b0, seen_busy}, {31'b0, exp_glitch});
      check("t6_idle_after", {31'b0, busy}, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
